// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the Hack ALU as its only adder.
// Returns the low WIDTH bits of a*b; the CPU stalls on busy until done pulses.
module alu_mul_seq #(
  parameter int WIDTH      = 16,    // must match the ALU; only 16 is supported
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_zr,
  output logic             result_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACC,
    S_DBL,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_bitcnt;
  logic             w_finish;
  logic             w_add;

  assign w_finish = (EARLY_EXIT && (r_mplier == '0)) || (r_bitcnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Outside ACC/DBL the ALU is parked on zx=1,zy=1,f=0 so it quietly computes 0.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    w_add       = 1'b0;
    alu_x       = '0;
    alu_y       = '0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_finish)         w_state_nxt = S_DONE;
        else if (r_mplier[0]) w_state_nxt = S_ACC;
        else                  w_state_nxt = S_DBL;
      end
      S_ACC: begin
        w_add       = 1'b1;
        alu_x       = r_acc;
        alu_y       = r_mcand;
        w_state_nxt = S_DBL;
      end
      S_DBL: begin
        w_add       = 1'b1;
        alu_x       = r_mcand;
        alu_y       = r_mcand;
        w_state_nxt = S_CHECK;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign alu_zx = ~w_add;
  assign alu_nx = 1'b0;
  assign alu_zy = ~w_add;
  assign alu_ny = 1'b0;
  assign alu_f  = w_add;
  assign alu_no = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_bitcnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_acc    <= '0;
          r_mcand  <= a;
          r_mplier <= b;
          r_bitcnt <= '0;
        end
        S_ACC: r_acc <= alu_out;
        S_DBL: begin
          r_mcand  <= alu_out;
          r_mplier <= r_mplier >> 1;
          r_bitcnt <= r_bitcnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result    = r_acc;
  assign result_zr = (r_acc == '0);
  assign result_ng = r_acc[WIDTH-1];

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (early exit on/off), each wired to a bench Hack ALU,
// checked every cycle against a latency/product model plus directed literal expectations.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [2];
  logic [15:0] a [2];
  logic [15:0] b [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic [15:0] res_w [2];
  logic        zr_w [2];
  logic        ng_w [2];
  logic [15:0] ax_w [2];
  logic [15:0] ay_w [2];
  logic [15:0] aout_w [2];
  logic        zx_w [2], nx_w [2], zy_w [2], ny_w [2], f_w [2], no_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic zx, input logic nx, input logic zy,
                                           input logic ny, input logic f, input logic no);
    logic [15:0] xx, yy, o;
    xx = zx ? 16'h0 : x;
    xx = nx ? ~xx : xx;
    yy = zy ? 16'h0 : y;
    yy = ny ? ~yy : yy;
    o  = f ? xx + yy : xx & yy;
    return no ? ~o : o;
  endfunction

  assign aout_w[0] = hack_alu(ax_w[0], ay_w[0], zx_w[0], nx_w[0], zy_w[0], ny_w[0], f_w[0], no_w[0]);
  assign aout_w[1] = hack_alu(ax_w[1], ay_w[1], zx_w[1], nx_w[1], zy_w[1], ny_w[1], f_w[1], no_w[1]);

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .reset(reset), .start(start[0]), .a(a[0]), .b(b[0]),
    .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0]), .result_zr(zr_w[0]), .result_ng(ng_w[0]),
    .alu_x(ax_w[0]), .alu_y(ay_w[0]), .alu_zx(zx_w[0]), .alu_nx(nx_w[0]), .alu_zy(zy_w[0]),
    .alu_ny(ny_w[0]), .alu_f(f_w[0]), .alu_no(no_w[0]), .alu_out(aout_w[0]));

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .reset(reset), .start(start[1]), .a(a[1]), .b(b[1]),
    .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1]), .result_zr(zr_w[1]), .result_ng(ng_w[1]),
    .alu_x(ax_w[1]), .alu_y(ay_w[1]), .alu_zx(zx_w[1]), .alu_nx(nx_w[1]), .alu_zy(zy_w[1]),
    .alu_ny(ny_w[1]), .alu_f(f_w[1]), .alu_no(no_w[1]), .alu_out(aout_w[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl(input int i);
    return {zx_w[i], nx_w[i], zy_w[i], ny_w[i], f_w[i], no_w[i]};
  endfunction

  function automatic int popcnt(input logic [15:0] v);
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic int bitlen(input logic [15:0] v);
    int n = 0;
    for (int k = 0; k < 16; k++) if (v[k]) n = k + 1;
    return n;
  endfunction

  // Model: cycles left in the current operation (done on the last one), expected product, adds.
  int          m_cnt [2];
  logic [15:0] m_exp [2];
  int          m_adds [2];
  int          adds [2];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_cnt[i] = 0;
        m_exp[i] = 16'h0;
      end else if (m_cnt[i] == 0) begin
        if (start[i]) begin
          int len;
          len       = (i == 0) ? bitlen(b[i]) : 16;
          m_cnt[i]  = 2 * len + popcnt(b[i]) + 2;
          m_adds[i] = len + popcnt(b[i]);
          m_exp[i]  = 16'((32'(a[i]) * 32'(b[i])) & 32'hFFFF);
        end
      end else begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        adds[i] = 0;
      end else begin
        logic exp_done;
        exp_done = (m_cnt[i] == 1);
        chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_cnt[i] != 0));
        chk($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(exp_done));
        if (m_cnt[i] == 0 || exp_done) begin
          chk($sformatf("result[%0d]", i), 32'(res_w[i]), 32'(m_exp[i]));
          chk($sformatf("zr[%0d]", i), 32'(zr_w[i]), 32'(m_exp[i] == 16'h0));
          chk($sformatf("ng[%0d]", i), 32'(ng_w[i]), 32'(m_exp[i][15]));
        end
        if (ctl(i) == 6'b000010) adds[i]++;
        else chk($sformatf("idle_code[%0d]", i), {ctl(i), ax_w[i] | ay_w[i]}, {6'b101000, 16'h0});
        if (exp_done) begin
          chk($sformatf("add_cycles[%0d]", i), 32'(adds[i]), 32'(m_adds[i]));
          adds[i] = 0;
        end
      end
    end
  end

  // Directed op with literal expectations; caller guarantees the instance is idle.
  task automatic run_op(input int i, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_res, input int exp_cyc, input int exp_adds);
    int n = 0;
    int na = 0;
    bit seen = 0;
    @(negedge clk);
    a[i] = av; b[i] = bv; start[i] = 1'b1;
    while (n < 200 && !seen) begin
      @(negedge clk);
      start[i] = 1'b0;
      n++;
      if (ctl(i) == 6'b000010) na++;
      seen = done_w[i];
    end
    chk($sformatf("done_seen %0h*%0h", av, bv), 32'(seen), 32'd1);
    chk($sformatf("latency %0h*%0h", av, bv), 32'(n), 32'(exp_cyc));
    chk($sformatf("adds %0h*%0h", av, bv), 32'(na), 32'(exp_adds));
    chk($sformatf("result %0h*%0h", av, bv), 32'(res_w[i]), 32'(exp_res));
    chk($sformatf("zr %0h*%0h", av, bv), 32'(zr_w[i]), 32'(exp_res == 16'h0));
    chk($sformatf("ng %0h*%0h", av, bv), 32'(ng_w[i]), 32'(exp_res[15]));
  endtask

  task automatic wait_done(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[i] && n < 200);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; a[i] = 16'h0; b[i] = 16'h0;
    end
    #1;
    chk("reset busy", 32'(busy_w[0]), 32'd0);
    chk("reset result", 32'(res_w[0]), 32'd0);
    chk("reset zr", 32'(zr_w[0]), 32'd1);
    chk("reset alu code", {ctl(0), ax_w[0] | ay_w[0]}, {6'b101000, 16'h0});
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    a[0] = 16'd3; b[0] = 16'd5; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset busy", 32'(busy_w[0]), 32'd0);
    chk("midreset done", 32'(done_w[0]), 32'd0);
    chk("midreset result", 32'(res_w[0]), 32'd0);
    chk("midreset zr", 32'(zr_w[0]), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    run_op(0, 16'd2, 16'd2, 16'd4, 7, 3);

    run_op(0, 16'd3, 16'd5, 16'd15, 10, 5);
    run_op(0, 16'h1234, 16'h0000, 16'h0000, 2, 0);
    run_op(0, 16'hFFFF, 16'hFFFF, 16'h0001, 50, 32);
    run_op(0, 16'hFFFF, 16'd7, 16'hFFF9, 11, 6);
    run_op(0, 16'h0100, 16'h0100, 16'h0000, 21, 10);
    run_op(0, 16'd300, 16'd300, 16'h5F90, 24, 13);

    // start held high: one done, one IDLE cycle, then relaunch; operand changes while busy ignored
    @(negedge clk);
    a[0] = 16'd3; b[0] = 16'd5; start[0] = 1'b1;
    wait_done(0, n);
    chk("held latency", 32'(n), 32'd10);
    @(negedge clk);
    chk("held idle gap busy", 32'(busy_w[0]), 32'd0);
    chk("held idle gap done", 32'(done_w[0]), 32'd0);
    @(negedge clk);
    chk("held relaunch busy", 32'(busy_w[0]), 32'd1);
    a[0] = 16'd7; b[0] = 16'd9; start[0] = 1'b0;
    wait_done(0, n);
    chk("held second latency", 32'(n), 32'd9);
    chk("held second result", 32'(res_w[0]), 32'd15);

    run_op(1, 16'd3, 16'd5, 16'd15, 36, 18);
    run_op(1, 16'hFFFF, 16'd7, 16'hFFF9, 37, 19);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
